// File: rtl/cfi_lp_tracker_pkg.sv
// Shared types and constants for the Zicfilp landing-pad tracker.
package cfi_lp_tracker_pkg;

  // Architectural expected-landing-pad value as seen by the CSR file (xPELP).
  typedef enum logic {
    NO_LP_EXPECTED = 1'b0,
    LP_EXPECTED    = 1'b1
  } elp_t;

  // Tracker state: IDLE = ELP clear, EXPECT = ELP set, FAULT = exception pending.
  typedef enum logic [1:0] {
    LP_IDLE   = 2'd0,
    LP_EXPECT = 2'd1,
    LP_FAULT  = 2'd2
  } lp_state_e;

  localparam int unsigned SW_CHECK_CAUSE = 18;
  localparam int unsigned LP_FAULT_TVAL  = 2;

  // A label width of 0 disables label matching; keep at least one bit of
  // storage so every vector stays legal.
  function automatic int unsigned label_bits(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/cfi_lp_tracker_if.sv
// Commit-side and exception-side signals of the landing-pad tracker.
// Handshake: there is no backpressure. commit_valid_i[k] qualifies port k in
// the cycle it is high; commit_kill_o[k] answers in the same cycle. ex_valid_o
// stays high until the cycle trap_ack_i is seen, and drops the cycle after.
interface cfi_lp_tracker_if
  import cfi_lp_tracker_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned LabelWidth    = 20,
  parameter int unsigned XLEN          = 64
) ();
  localparam int unsigned LW = label_bits(LabelWidth);

  logic [NrCommitPorts-1:0]         commit_valid_i;
  logic [NrCommitPorts-1:0]         is_ind_jump_i;
  logic [NrCommitPorts-1:0]         is_lpad_i;
  logic [NrCommitPorts-1:0][LW-1:0] lpad_label_i;
  logic [NrCommitPorts-1:0][LW-1:0] jump_label_i;
  logic                             lpe_i;
  logic                             debug_mode_i;
  logic                             xret_i;
  logic                             xret_elp_i;
  logic                             trap_i;
  logic                             trap_ack_i;
  logic                             elp_o;
  logic [NrCommitPorts-1:0]         commit_kill_o;
  logic                             ex_valid_o;
  logic [XLEN-1:0]                  ex_cause_o;
  logic [XLEN-1:0]                  ex_tval_o;
  lp_state_e                        state_o;

  modport master (
    output commit_valid_i, is_ind_jump_i, is_lpad_i, lpad_label_i, jump_label_i,
    output lpe_i, debug_mode_i, xret_i, xret_elp_i, trap_i, trap_ack_i,
    input  elp_o, commit_kill_o, ex_valid_o, ex_cause_o, ex_tval_o, state_o
  );

  modport slave (
    input  commit_valid_i, is_ind_jump_i, is_lpad_i, lpad_label_i, jump_label_i,
    input  lpe_i, debug_mode_i, xret_i, xret_elp_i, trap_i, trap_ack_i,
    output elp_o, commit_kill_o, ex_valid_o, ex_cause_o, ex_tval_o, state_o
  );
endinterface

// File: rtl/cfi_lp_tracker_lp_port_check.sv
// One commit port of the landing-pad scan. Takes the running ELP state and
// label from the lower port and hands the updated pair to the next port.
module cfi_lp_tracker_lp_port_check
  import cfi_lp_tracker_pkg::*;
#(
  parameter int unsigned LabelWidth = 20,
  localparam int unsigned LW = label_bits(LabelWidth)
) (
  input  logic          valid_i,
  input  logic          is_ind_jump_i,
  input  logic          is_lpad_i,
  input  logic [LW-1:0] lpad_label_i,
  input  logic [LW-1:0] jump_label_i,
  input  logic          checks_on_i,
  input  lp_state_e     state_i,
  input  logic [LW-1:0] label_i,
  input  logic          killed_i,
  output lp_state_e     state_o,
  output logic [LW-1:0] label_o,
  output logic          violation_o,
  output logic          kill_o
);
  logic live;
  logic mismatch;
  logic viol;

  // A killed port never executes, so it neither checks nor sets ELP.
  assign live = valid_i && !killed_i && checks_on_i;
  // Label 0 on the LPAD is a wildcard; width 0 means presence-only checking.
  assign mismatch = (LabelWidth > 0) && (lpad_label_i != '0) && (lpad_label_i != label_i);

  // Check this port against the running state, then apply its own jump.
  always_comb begin
    state_o = state_i;
    label_o = label_i;
    viol    = 1'b0;
    if (live && (state_i == LP_EXPECT)) begin
      if (!is_lpad_i || mismatch) viol = 1'b1;
      else                        state_o = LP_IDLE;
    end
    if (live && !viol && is_ind_jump_i) begin
      state_o = LP_EXPECT;
      label_o = jump_label_i;
    end
  end

  assign violation_o = viol;
  assign kill_o      = killed_i | viol;
endmodule

// File: rtl/cfi_lp_tracker.sv
// Zicfilp landing-pad tracker for the commit path: holds ELP and the expected
// label, scans retiring ports in order and raises a registered software-check
// exception on a landing-pad violation.
module cfi_lp_tracker
  import cfi_lp_tracker_pkg::*;
#(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned LabelWidth    = 20,
  parameter int unsigned XLEN          = 64
) (
  input logic             clk_i,
  input logic             rst_i,
  cfi_lp_tracker_if.slave lp
);
  localparam int unsigned LW = label_bits(LabelWidth);

  lp_state_e       state_q, state_d;
  logic [LW-1:0]   exp_label_q, exp_label_d;
  logic            ex_valid_q;
  logic [XLEN-1:0] ex_cause_q, ex_tval_q;
  logic            checks_on;
  elp_t            elp;

  lp_state_e                run_state [NrCommitPorts+1];
  logic [LW-1:0]            run_label [NrCommitPorts+1];
  logic                     run_kill  [NrCommitPorts+1];
  logic [NrCommitPorts-1:0] viol;
  logic [NrCommitPorts-1:0] kill_scan;

  // Outside debug and with xLPE set, violations are raised and ELP is set.
  assign checks_on = lp.lpe_i && !lp.debug_mode_i;

  // The scan starts from the registered state; FAULT never reaches it because
  // all ports are killed while the exception is pending.
  assign run_state[0] = (state_q == LP_EXPECT) ? LP_EXPECT : LP_IDLE;
  assign run_label[0] = exp_label_q;
  assign run_kill[0]  = 1'b0;

  for (genvar k = 0; k < NrCommitPorts; k++) begin : g_port
    cfi_lp_tracker_lp_port_check #(
      .LabelWidth (LabelWidth)
    ) u_check (
      .valid_i       (lp.commit_valid_i[k]),
      .is_ind_jump_i (lp.is_ind_jump_i[k]),
      .is_lpad_i     (lp.is_lpad_i[k]),
      .lpad_label_i  (lp.lpad_label_i[k]),
      .jump_label_i  (lp.jump_label_i[k]),
      .checks_on_i   (checks_on),
      .state_i       (run_state[k]),
      .label_i       (run_label[k]),
      .killed_i      (run_kill[k]),
      .state_o       (run_state[k+1]),
      .label_o       (run_label[k+1]),
      .violation_o   (viol[k]),
      .kill_o        (run_kill[k+1])
    );
    assign kill_scan[k] = run_kill[k+1];
  end

  // Next state: ack in FAULT, then trap, then xRET, then the commit scan.
  always_comb begin
    state_d     = state_q;
    exp_label_d = exp_label_q;
    if (state_q == LP_FAULT) begin
      if (lp.trap_ack_i) begin
        state_d     = LP_IDLE;
        exp_label_d = '0;
      end
    end else if (lp.trap_i) begin
      state_d     = LP_IDLE;
      exp_label_d = '0;
    end else if (lp.xret_i) begin
      state_d     = lp.xret_elp_i ? LP_EXPECT : LP_IDLE;
      exp_label_d = '0;
    end else if (|viol) begin
      state_d = LP_FAULT;
    end else begin
      state_d     = run_state[NrCommitPorts];
      exp_label_d = run_label[NrCommitPorts];
    end
  end

  // State, label and exception registers; the exception mirrors the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= LP_IDLE;
      exp_label_q <= '0;
      ex_valid_q  <= 1'b0;
      ex_cause_q  <= '0;
      ex_tval_q   <= '0;
    end else begin
      state_q     <= state_d;
      exp_label_q <= exp_label_d;
      ex_valid_q  <= (state_d == LP_FAULT);
      ex_cause_q  <= (state_d == LP_FAULT) ? XLEN'(SW_CHECK_CAUSE) : '0;
      ex_tval_q   <= (state_d == LP_FAULT) ? XLEN'(LP_FAULT_TVAL) : '0;
    end
  end

  // FAULT keeps ELP high so the CSR file saves xPELP = LP_EXPECTED.
  assign elp = (state_q == LP_IDLE) ? NO_LP_EXPECTED : LP_EXPECTED;

  assign lp.elp_o         = (elp == LP_EXPECTED);
  assign lp.commit_kill_o = (state_q == LP_FAULT) ? '1 : kill_scan;
  assign lp.ex_valid_o    = ex_valid_q;
  assign lp.ex_cause_o    = ex_cause_q;
  assign lp.ex_tval_o     = ex_tval_q;
  assign lp.state_o       = state_q;
endmodule

// File: tb/tb_cfi_lp_tracker.sv
// Directed bench for cfi_lp_tracker: one instance with 20-bit labels and one
// with label matching disabled, driven with identical stimulus.
module tb_cfi_lp_tracker;
  import cfi_lp_tracker_pkg::*;

  logic clk;
  logic rst;
  int   tests_run = 0;
  int   fails     = 0;

  // Expected per cycle: {kill0[1:0], elp0, exv0, kill1[1:0], elp1, exv1}
  logic [7:0] exp_q[$];

  cfi_lp_tracker_if #(.NrCommitPorts(2), .LabelWidth(20), .XLEN(64)) if0 ();
  cfi_lp_tracker_if #(.NrCommitPorts(2), .LabelWidth(0),  .XLEN(64)) if1 ();

  cfi_lp_tracker #(.NrCommitPorts(2), .LabelWidth(20), .XLEN(64)) dut0 (
    .clk_i (clk), .rst_i (rst), .lp (if0)
  );
  cfi_lp_tracker #(.NrCommitPorts(2), .LabelWidth(0), .XLEN(64)) dut1 (
    .clk_i (clk), .rst_i (rst), .lp (if1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [1:0] v, j, l,
                      input logic [19:0] ll0, ll1, jl0, jl1,
                      input logic lpe, dbg, xr, xe, tr, ak,
                      input logic chk, input logic [7:0] e);
    @(posedge clk);
    #1;
    rst = r;
    if0.commit_valid_i = v;  if1.commit_valid_i = v;
    if0.is_ind_jump_i  = j;  if1.is_ind_jump_i  = j;
    if0.is_lpad_i      = l;  if1.is_lpad_i      = l;
    if0.lpad_label_i[0] = ll0; if0.lpad_label_i[1] = ll1;
    if0.jump_label_i[0] = jl0; if0.jump_label_i[1] = jl1;
    if1.lpad_label_i[0] = ll0[0]; if1.lpad_label_i[1] = ll1[0];
    if1.jump_label_i[0] = jl0[0]; if1.jump_label_i[1] = jl1[0];
    if0.lpe_i = lpe;        if1.lpe_i = lpe;
    if0.debug_mode_i = dbg; if1.debug_mode_i = dbg;
    if0.xret_i = xr;        if1.xret_i = xr;
    if0.xret_elp_i = xe;    if1.xret_elp_i = xe;
    if0.trap_i = tr;        if1.trap_i = tr;
    if0.trap_ack_i = ak;    if1.trap_ack_i = ak;
    if (chk) exp_q.push_back(e);
  endtask

  task automatic idle(input logic [7:0] e);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, e);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests_run++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("kill0",  64'(if0.commit_kill_o), 64'(e[7:6]));
        check("elp0",   64'(if0.elp_o),         64'(e[5]));
        check("exv0",   64'(if0.ex_valid_o),    64'(e[4]));
        check("cause0", if0.ex_cause_o,         e[4] ? 64'd18 : 64'd0);
        check("tval0",  if0.ex_tval_o,          e[4] ? 64'd2  : 64'd0);
        check("kill1",  64'(if1.commit_kill_o), 64'(e[3:2]));
        check("elp1",   64'(if1.elp_o),         64'(e[1]));
        check("exv1",   64'(if1.ex_valid_o),    64'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int waited;
    rst = 1'b1;
    // reset
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    // jump p0 + matching LPAD p1 same cycle: no kill, ELP stays clear
    step(0, 2'b11, 2'b01, 2'b10, 0, 20'h00123, 20'h00123, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    idle(8'b0000_0000);
    // jump on last port, then non-LPAD on port 0 -> kill 11, fault, ack
    step(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 20'h00005, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b1110_1110);
    idle(8'b1111_1111);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 8'b1111_1111);
    idle(8'b0000_0000);
    // label mismatch 5 vs 6: faults only with label matching enabled
    step(0, 2'b01, 2'b01, 2'b00, 0, 0, 20'h00005, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b00, 2'b01, 20'h00006, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b1110_0010);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 8'b1111_0000);
    idle(8'b0000_0000);
    // wildcard LPAD label 0 passes
    step(0, 2'b01, 2'b01, 2'b00, 0, 0, 20'h00005, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0010_0010);
    idle(8'b0000_0000);
    // lpe=0 and debug mode: jump then ADD, nothing tracked
    step(0, 2'b01, 2'b01, 2'b00, 0, 0, 20'h00005, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b01, 2'b00, 0, 0, 20'h00005, 0, 1, 1, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 8'b0000_0000);
    idle(8'b0000_0000);
    // trap clears ELP; xRET restores it; non-LPAD then faults
    step(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, 20'h00009, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 8'b0010_0010);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b1110_1110);
    idle(8'b1111_1111);
    // reset while in FAULT
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b1111_1111);
    idle(8'b0000_0000);
    // jump p0 + mismatching LPAD p1 same cycle: only port 1 killed
    step(0, 2'b11, 2'b01, 2'b10, 0, 20'h00008, 20'h00007, 0, 1, 0, 0, 0, 0, 0, 1, 8'b1000_0000);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 8'b1111_0000);
    idle(8'b0000_0000);
    // xRET with xPELP=0 clears ELP
    step(0, 2'b01, 2'b01, 2'b00, 0, 0, 20'h00003, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 8'b0010_0010);
    step(0, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 8'b0000_0000);
    idle(8'b0000_0000);
    // drain the scoreboard
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/cfi_lp_tracker.md
# cfi_lp_tracker

Parametrised Zicfilp landing-pad tracker for the commit path. Holds the architectural expected-landing-pad (ELP) state and the expected label across cycles, checks up to NrCommitPorts retiring instructions per cycle in program order, and raises a registered software-check exception on a landing-pad violation. It supersedes the single-instruction, combinational LPAD check in the branch unit. It sits beside commit_stage and feeds csr_regfile (ELP save/restore) and the exception path.

## Interface
- NrCommitPorts, 2: instructions checked per cycle, retiring in order from port 0 upward.
- LabelWidth, 20: landing-pad label width, taken from x7[31:12]. 0 disables label matching; only pad presence is checked.
- XLEN, 64: width of the exception tval field.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- commit_valid_i  in  NrCommitPorts  instruction retiring on port k.
- is_ind_jump_i  in  NrCommitPorts  JALR with rs1 not in {x1, x5, x7}; sets ELP.
- is_lpad_i  in  NrCommitPorts  instruction is LPAD.
- lpad_label_i  in  NrCommitPorts x LabelWidth  immediate label of the LPAD.
- jump_label_i  in  NrCommitPorts x LabelWidth  x7[31:12] read when the jump executed.
- lpe_i  in  1  xLPE enable for the current privilege.
- debug_mode_i  in  1  debug mode; all checks off.
- xret_i  in  1  xRET retiring.
- xret_elp_i  in  1  xPELP value restored by the xRET.
- trap_i  in  1  any other trap taken (interrupt or exception).
- trap_ack_i  in  1  csr_regfile accepted this block's exception.
- elp_o  out  1  current ELP (1 = LP_EXPECTED), sampled by csr_regfile into xPELP.
- commit_kill_o  out  NrCommitPorts  port must not retire; combinational.
- ex_valid_o  out  1  landing-pad fault pending.
- ex_cause_o  out  XLEN  18 (software check).
- ex_tval_o  out  XLEN  2 (landing-pad fault).

## Operation
- States: IDLE (ELP clear), EXPECT (ELP set, label held in exp_label_q), FAULT (exception pending).
- In-cycle scan, ports 0..N-1, using a running copy of state and label:
  - Valid port in EXPECT: if the port is not LPAD, or LabelWidth>0 and the label is nonzero and differs from the expected label, it is the violating port. Otherwise the running state becomes IDLE.
  - Violation: that port and all higher ports get commit_kill_o=1. Next state is FAULT.
  - Valid unkilled port with is_ind_jump_i and lpe_i: the running state becomes EXPECT, the label becomes jump_label_i[k], and the check applies to the next valid port in the same cycle.
  - Invalid ports are transparent.
- An LPAD label of 0 matches any expected label.
- In IDLE an LPAD executes as a no-op; it is never a fault.
- debug_mode_i=1 or lpe_i=0: no violation is raised and no ELP is set. The ELP register still holds its value so xPELP stays correct across mode changes.
- FAULT:
  - commit_kill_o is all ones.
  - ex_valid_o=1, ex_cause_o=18, ex_tval_o=2.
  - elp_o stays 1 so the CSR file saves xPELP=LP_EXPECTED.
  - On trap_ack_i go to IDLE.
- trap_i (not in FAULT): next state IDLE. elp_o keeps its pre-trap value during the trap cycle.
- xret_i: next state is EXPECT if xret_elp_i is 1, else IDLE. The expected label becomes 0 (wildcard).
- Priority, highest first: rst_i > trap_ack_i (in FAULT) > trap_i > xret_i > commit scan.

## Timing
- Reset: state IDLE, exp_label_q=0, elp_o=0, ex_valid_o=0, ex_cause_o=0, ex_tval_o=0, commit_kill_o=0.
- commit_kill_o: zero latency, same cycle as the violating commit.
- ex_valid_o: asserted the cycle after the violation. Held with stable cause and tval until the cycle of trap_ack_i. Low the cycle after the ack.
- elp_o is registered and changes the cycle after a jump or LPAD retires.
- A jump on the last port sets elp_o next cycle; the next cycle's port 0 is checked against it.
- Jump plus matching LPAD in the same cycle leaves elp_o=0.
- trap_ack_i outside FAULT is ignored.
- Reset in FAULT clears everything; no exception survives reset.

## Structure
- Shared package (ariane_pkg / riscv): reuse riscv::elp; add SW_CHECK_CAUSE=18 and LP_FAULT_TVAL=2 constants; add a typedef for the tracker state enum.
- Sub-module lp_port_check: combinational, one port. Inputs are running state and label; outputs are next state, next label and violation. It is chained NrCommitPorts times in a generate loop.
- The top level holds the state and label registers, the priority mux and the exception register.

## Test plan
- JALR on port 0 with jump_label 0x00123, LPAD label 0x00123 on port 1, same cycle -> no kill, elp_o stays 0.
- JALR on port 1 with label 0x00005, ADD on port 0 next cycle -> commit_kill_o=2'b11 that cycle; next cycle ex_valid_o=1, cause 18, tval 2, elp_o=1; after trap_ack_i, ex_valid_o=0 and elp_o=0.
- Expected label 0x00005, LPAD label 0x00006 -> fault. Same sequence with LPAD label 0 -> passes. Same sequence with LabelWidth=0 -> passes.
- lpe_i=0 or debug_mode_i=1: JALR then ADD -> no kill, elp_o stays 0.
- elp_o=1, trap_i -> elp_o=0 next cycle. Then xret_i with xret_elp_i=1 -> elp_o=1. Next port 0 not LPAD -> fault.
- rst_i asserted while in FAULT -> all outputs return to reset values next cycle.
